// File: rtl/hazard_fwd_ctrl_if.sv
// Hazard/forwarding controller bus: ID-stage fields in, forwarding selects and
// front-end stall/bubble controls out.
interface hazard_fwd_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_muldiv;
  logic       flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       pc_we;
  logic       ifid_we;
  logic       idex_bubble;
  logic       exmem_bubble;
  logic       md_busy;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwrite, id_memread, id_muldiv, flush,
    input  fwd_a_sel, fwd_b_sel, pc_we, ifid_we,
           idex_bubble, exmem_bubble, md_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwrite, id_memread, id_muldiv, flush,
    output fwd_a_sel, fwd_b_sel, pc_we, ifid_we,
           idex_bubble, exmem_bubble, md_busy
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// 5-stage MIPS hazard/forwarding controller: shadow pipeline fields, operand
// forwarding selects, load-use and flush bubbles. HAZ_MULDIV_EN adds the mult/div interlock.
module hazard_fwd_ctrl #(
  parameter int MULDIV_LAT = 4
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_ctrl_if.slave bus
);

  logic [4:0] r_ex_rs, r_ex_rt, r_ex_rd;
  logic       r_ex_regwrite, r_ex_memread;
  logic [4:0] r_mem_rd, r_wb_rd;
  logic       r_mem_regwrite, r_wb_regwrite;

  logic w_ex_writes, w_mem_writes, w_wb_writes;
  logic w_load_use, w_stall, w_md_active;
  logic w_idex_bubble, w_exmem_bubble;

  // Register 0 is hardwired, so a "write" to it never forwards or interlocks.
  assign w_ex_writes  = r_ex_regwrite  && (r_ex_rd  != 5'd0);
  assign w_mem_writes = r_mem_regwrite && (r_mem_rd != 5'd0);
  assign w_wb_writes  = r_wb_regwrite  && (r_wb_rd  != 5'd0);

  logic [4:0] w_src [2];
  logic [1:0] w_sel [2];
  assign w_src[0] = r_ex_rs;
  assign w_src[1] = r_ex_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign w_sel[gi] = (w_mem_writes && (r_mem_rd == w_src[gi])) ? 2'b10 :
                         (w_wb_writes  && (r_wb_rd  == w_src[gi])) ? 2'b01 : 2'b00;
    end
  endgenerate

  assign bus.fwd_a_sel = w_sel[0];
  assign bus.fwd_b_sel = w_sel[1];

  assign w_load_use = r_ex_memread && w_ex_writes &&
                      ((bus.id_uses_rs && (bus.id_rs == r_ex_rd)) ||
                       (bus.id_uses_rt && (bus.id_rt == r_ex_rd)));

  // A taken branch kills the ID instruction, so its load-use hazard is moot.
  assign w_stall        = w_load_use && !bus.flush;
  assign w_idex_bubble  = !w_md_active && (bus.flush || w_load_use);
  assign w_exmem_bubble = w_md_active;

  assign bus.pc_we        = !w_md_active && !w_stall;
  assign bus.ifid_we      = !w_md_active && !w_stall;
  assign bus.idex_bubble  = w_idex_bubble;
  assign bus.exmem_bubble = w_exmem_bubble;
  assign bus.md_busy      = w_md_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_rs        <= 5'd0;
      r_ex_rt        <= 5'd0;
      r_ex_rd        <= 5'd0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_rd       <= 5'd0;
      r_mem_regwrite <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_regwrite  <= 1'b0;
    end else begin
      if (!w_md_active) begin
        if (w_idex_bubble) begin
          r_ex_rs       <= 5'd0;
          r_ex_rt       <= 5'd0;
          r_ex_rd       <= 5'd0;
          r_ex_regwrite <= 1'b0;
          r_ex_memread  <= 1'b0;
        end else begin
          r_ex_rs       <= bus.id_rs;
          r_ex_rt       <= bus.id_rt;
          r_ex_rd       <= bus.id_rd;
          r_ex_regwrite <= bus.id_regwrite;
          r_ex_memread  <= bus.id_memread;
        end
      end
      if (w_exmem_bubble) begin
        r_mem_rd       <= 5'd0;
        r_mem_regwrite <= 1'b0;
      end else begin
        r_mem_rd       <= r_ex_rd;
        r_mem_regwrite <= r_ex_regwrite;
      end
      r_wb_rd       <= r_mem_rd;
      r_wb_regwrite <= r_mem_regwrite;
    end
  end

`ifdef HAZ_MULDIV_EN
  typedef enum logic {S_IDLE, S_MD_BUSY} state_t;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LAT - 2);

  state_t     r_state, w_state_next;
  logic [3:0] r_md_cnt, w_md_cnt_next;
  logic       r_ex_muldiv;
  logic       w_md_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_md_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_next;
      r_md_cnt <= w_md_cnt_next;
    end
  end

  // w_md_last marks the final stalled cycle; the held op then advances next cycle.
  always_comb begin
    w_state_next  = r_state;
    w_md_cnt_next = r_md_cnt;
    w_md_active   = 1'b0;
    w_md_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ex_muldiv) begin
          w_md_active = 1'b1;
          if (MD_LOAD == 4'd0) begin
            w_md_last = 1'b1;
          end else begin
            w_state_next  = S_MD_BUSY;
            w_md_cnt_next = MD_LOAD;
          end
        end
      end
      S_MD_BUSY: begin
        w_md_active   = 1'b1;
        w_md_cnt_next = (r_md_cnt == 4'd0) ? 4'd0 : r_md_cnt - 4'd1;
        if (r_md_cnt <= 4'd1) begin
          w_md_last    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Clearing the held muldiv bit on release stops IDLE from re-arming on the same op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_muldiv <= 1'b0;
    end else if (w_md_active) begin
      if (w_md_last) begin
        r_ex_muldiv <= 1'b0;
      end
    end else if (w_idex_bubble) begin
      r_ex_muldiv <= 1'b0;
    end else begin
      r_ex_muldiv <= bus.id_muldiv;
    end
  end
`else
  logic w_unused;

  assign w_md_active = 1'b0;
  assign w_unused    = ^{bus.id_muldiv, 4'(MULDIV_LAT)};
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl; mult/div steps follow HAZ_MULDIV_EN.
module tb_hazard_fwd_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  hazard_fwd_ctrl_if bus ();

  hazard_fwd_ctrl #(.MULDIV_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed expectation: {fwd_a, fwd_b, pc_we, ifid_we, idex_bubble, exmem_bubble, md_busy}
  localparam logic [8:0] E_IDLE  = 9'b00_00_1_1_0_0_0;
  localparam logic [8:0] E_LU    = 9'b00_00_0_0_1_0_0;
  localparam logic [8:0] E_FLUSH = 9'b00_00_1_1_1_0_0;
  localparam logic [8:0] E_MD    = 9'b00_00_0_0_0_1_1;

  task automatic step(input string tag,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt,
                      input logic [4:0] rd, input logic rw, input logic mr,
                      input logic md, input logic fl,
                      input logic [8:0] exp_v);
    logic [8:0] obs;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_muldiv   = md;
    bus.flush       = fl;
    #4;
    obs = {bus.fwd_a_sel, bus.fwd_b_sel, bus.pc_we, bus.ifid_we,
           bus.idex_bubble, bus.exmem_bubble, bus.md_busy};
    n_vec++;
    $display("step %-18s obs=%b exp=%b", tag, obs, exp_v);
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input string tag, input logic [8:0] exp_v);
    step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_v);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_rd = 5'd0; bus.id_regwrite = 1'b0; bus.id_memread = 1'b0;
    bus.id_muldiv = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    nop("reset_idle", E_IDLE);
    // add $3 ; sub $4,$3,$3 ; or $5,$3,.. ; addi $0
    step("add_r3",    5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("sub_in_id", 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("fwd_exmem", 5'd3, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 9'b10_10_1_1_0_0_0);
    step("fwd_memwb", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b01_00_1_1_0_0_0);
    nop("idle_mid", E_IDLE);
    nop("r0_exmem", E_IDLE);
    nop("r0_memwb", E_IDLE);

    // Two writers of $7 in EX/MEM and MEM/WB, reader in ID/EX
    step("add_r7_a",  5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("add_r7_b",  5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("use_r7",    5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    nop("fwd_priority", 9'b10_00_1_1_0_0_0);
    nop("drain", E_IDLE);

    // lw $5 followed by a consumer of $5 on rt
    step("lw_r5",       5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E_IDLE);
    step("load_use",    5'd0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
    step("lu_resolved", 5'd0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    nop("lu_fwd_memwb", 9'b00_01_1_1_0_0_0);

    // rt matches the load but is not read: no interlock
    step("lw_r9",        5'd0, 5'd0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, E_IDLE);
    step("lu_rt_unused", 5'd0, 5'd9, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("lw_r5_b",      5'd0, 5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 9'b00_10_1_1_0_0_0);
    step("lu_with_flush", 5'd5, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, E_FLUSH);
    nop("after_flush", E_IDLE);

    // A flushed load must not create a later interlock
    step("flush_lw_r12", 5'd0,  5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, E_FLUSH);
    step("use_r12",      5'd12, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    nop("drain2", E_IDLE);

`ifdef HAZ_MULDIV_EN
    step("mult_in_id", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);
    step("md_entry",   5'd0, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, E_MD);
    step("md_busy2",   5'd0, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, E_MD);
    step("md_busy3",   5'd0, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, E_MD);
    step("md_release", 5'd0, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    nop("md_after", E_IDLE);

    step("mult2_in_id", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);
    nop("md2_entry", E_MD);
    rst = 1'b1;
    nop("md2_rst_cycle", E_MD);
    rst = 1'b0;
    nop("md2_after_rst", E_IDLE);
    nop("md2_idle", E_IDLE);
`else
    step("mult_no_md", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_IDLE);
    nop("no_md_stall", E_IDLE);
    nop("no_md_idle", E_IDLE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 5-stage MIPS core. It keeps its own shadow of the destination/control fields in ID/EX, EX/MEM and MEM/WB and drives the 2-bit selects of the two EX-stage ALU operand forwarding muxes. It also sequences front-end stalls: load-use interlock, branch flush bubbles and, optionally, a multi-cycle mult/div interlock. It sits beside the ID stage and drives the PC, IF/ID and ID/EX write-enable and bubble controls.

## Interface
- `MULDIV_LAT`, default 4: EX-stage mult/div latency in cycles, legal range 2..15.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs`, `id_rt` in 5: source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1: the ID instruction actually reads rs/rt.
- `id_rd` in 5: final destination register of the ID instruction (rt/rd/31 already selected).
- `id_regwrite`, `id_memread`, `id_muldiv` in 1: control bits of the ID instruction.
- `flush` in 1: branch/jump taken, resolved in EX; kill the instruction in ID.
- `fwd_a_sel`, `fwd_b_sel` out 2: operand mux selects. 00 = ID/EX value, 10 = EX/MEM result, 01 = MEM/WB result; 11 is never driven.
- `pc_we`, `ifid_we` out 1: PC and IF/ID write enables.
- `idex_bubble` out 1: load NOP control into ID/EX this cycle.
- `exmem_bubble` out 1: load NOP control into EX/MEM this cycle (mult/div busy).
- `md_busy` out 1: mult/div interlock active.

## Operation
- Shadow registers:
  - ID/EX: rs, rt, rd, regwrite, memread, muldiv.
  - EX/MEM: rd, regwrite.
  - MEM/WB: rd, regwrite.
- A stage "writes" rX only if regwrite=1 and rd≠0. Register 0 is never forwarded or interlocked.
- Shadow advance each cycle:
  - ID/EX ← ID fields, or all-zero when `idex_bubble`=1, or hold when frozen by MD_BUSY.
  - EX/MEM ← ID/EX, or zero when `exmem_bubble`=1.
  - MEM/WB ← EX/MEM always.
- Forwarding for operand A (uses ID/EX rs); operand B is identical using rt:
  - EX/MEM writes rs → 10.
  - Else MEM/WB writes rs → 01.
  - Else → 00.
  - EX/MEM has priority over MEM/WB.
- Load-use: ID/EX memread=1 and writes a register R, and the ID instruction uses rs=R or rt=R. Result: `pc_we`=0, `ifid_we`=0, `idex_bubble`=1 for exactly one cycle. The following cycle resolves by MEM/WB forwarding.
- Flush: `idex_bubble`=1 and ID fields discarded. Flush overrides a simultaneous load-use stall (pc_we=1, ifid_we=1).
- FSM, two states:
  - IDLE: when the ID/EX shadow has muldiv=1, the counter loads `MULDIV_LAT`−2 and the state goes to MD_BUSY.
  - MD_BUSY: `pc_we`=0, `ifid_we`=0, ID/EX shadow held, `idex_bubble`=0, `exmem_bubble`=1, `md_busy`=1. The counter decrements each cycle. When it reaches 0, the next cycle returns to IDLE and the mult/div advances to EX/MEM normally.
  - The entry cycle itself also asserts the MD_BUSY outputs. Total EX residency is `MULDIV_LAT` cycles.
  - `flush` is ignored while in MD_BUSY or on the entry cycle.
- Load-use detection and forwarding selects remain active during MD_BUSY, but `idex_bubble` is suppressed there.

## Timing
- `fwd_*_sel`, stall and bubble outputs are combinational from the shadow registers and current ID/flush inputs, valid in the same cycle.
- Reset values:
  - All shadow registers zero, FSM IDLE, counter 0.
  - Outputs: `fwd_a_sel`=`fwd_b_sel`=00, `pc_we`=`ifid_we`=1, `idex_bubble`=`exmem_bubble`=`md_busy`=0.
- `rst` asserted mid-MD_BUSY returns to IDLE on the next edge, with all shadows cleared.
- Load-use stall latency: 1 cycle. Mult/div stall: `MULDIV_LAT`−1 cycles.
- Counter width: 4 bits; no wrap, since it is loaded only from IDLE.

## Configuration
- `HAZ_MULDIV_EN` defined: FSM, counter, `id_muldiv` tracking and the mult/div interlock are compiled in.
- `HAZ_MULDIV_EN` undefined:
  - `id_muldiv` is ignored; no FSM or counter is built.
  - `md_busy`=`exmem_bubble`=0 constant.
  - Forwarding, load-use and flush behaviour are unchanged.

## Test plan
- After reset, idle with no writes → selects 00/00, `pc_we`=1, `ifid_we`=1, all bubbles 0.
- add $3 in EX, then sub using $3 as rs and rt → next cycle `fwd_a_sel`=10, `fwd_b_sel`=10. One cycle later an independent instruction using $3 → 01. Writes to $0 → 00.
- lw $5 in ID/EX and ID uses rt=$5:
  - That cycle: `pc_we`=0, `ifid_we`=0, `idex_bubble`=1.
  - Next cycle: no stall, `fwd_b_sel`=01.
  - Same pattern with `flush`=1 → no stall, `idex_bubble`=1.
- EX/MEM and MEM/WB both write $7 and ID/EX rs=$7 → `fwd_a_sel`=10.
- With `HAZ_MULDIV_EN` and MULDIV_LAT=4, mult enters EX:
  - `md_busy`=1 and `exmem_bubble`=1 for 3 cycles, `pc_we`=0 for 3 cycles, then IDLE.
  - `rst` asserted in cycle 2 → IDLE and reset outputs next cycle.
- Without `HAZ_MULDIV_EN`, `id_muldiv`=1 → no stall, `md_busy` stays 0.
